// File: rtl/alpha_beta_shifter_pkg.sv
// Shared encodings and sizes for the alpha/beta byte shifter and its ALU neighbour.
package alpha_beta_shifter_pkg;

  localparam int unsigned BYTES  = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned CNT_W  = $clog2(BYTES);

  // ALU state encoding as seen on st; only SEND matters to the shifter
  typedef enum logic [2:0] {
    ALU_IDLE = 3'b000,
    ALU_LOAD = 3'b001,
    ALU_MULT = 3'b010,
    ALU_REDC = 3'b011,
    ALU_HOLD = 3'b100,
    ALU_SEND = 3'b101,
    ALU_AUPD = 3'b110
  } alu_st_e;

endpackage

// File: rtl/alpha_beta_shifter_if.sv
// Byte streams, ALU handshake and status bundle for the alpha/beta shifter.
interface alpha_beta_shifter_if;
  import alpha_beta_shifter_pkg::*;

  logic [BYTE_W-1:0] RX_DATA;
  logic              RX_VALID;
  logic              RX_READY;
  logic [DATA_W-1:0] PD;
  logic              call;
  logic [2:0]        st;
  logic [DATA_W-1:0] RES;
  logic [BYTE_W-1:0] TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;
  logic              busy;
  logic              err;

  modport slave (
    input  RX_DATA, RX_VALID, st, RES, TX_READY,
    output RX_READY, PD, call, TX_DATA, TX_VALID, busy, err
  );

  modport master (
    output RX_DATA, RX_VALID, st, RES, TX_READY,
    input  RX_READY, PD, call, TX_DATA, TX_VALID, busy, err
  );

endinterface

// File: rtl/alpha_beta_shifter.sv
// Collects a 32-byte alpha, hands it to the ALU, then streams the 32-byte beta
// result back out; aborts to receive if the ALU never reaches SEND.
module alpha_beta_shifter
  import alpha_beta_shifter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input logic                 CLK,
  input logic                 RST,
  alpha_beta_shifter_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_RX   = 2'd0;
  localparam logic [1:0] S_CALL = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_TX   = 2'd3;

  logic [1:0]        state,    state_nxt;
  logic [DATA_W-1:0] sreg,     sreg_nxt;
  logic [CNT_W-1:0]  cnt,      cnt_nxt;
  logic [TW-1:0]     tcnt,     tcnt_nxt;
  logic              rx_ready, rx_ready_nxt;
  logic              call_q,   call_nxt;
  logic              busy_q,   busy_nxt;
  logic              err_q,    err_nxt;
  logic              tx_valid, tx_valid_nxt;
  logic [BYTE_W-1:0] tx_data,  tx_data_nxt;

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_RX;
      sreg     <= '0;
      cnt      <= '0;
      tcnt     <= '0;
      rx_ready <= 1'b1;
      call_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      cnt      <= cnt_nxt;
      tcnt     <= tcnt_nxt;
      rx_ready <= rx_ready_nxt;
      call_q   <= call_nxt;
      busy_q   <= busy_nxt;
      err_q    <= err_nxt;
      tx_valid <= tx_valid_nxt;
      tx_data  <= tx_data_nxt;
    end
  end

  // Next-state; the abort fires on the wait cycle that makes err land
  // exactly TIMEOUT cycles after the call cycle.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    tcnt_nxt  = tcnt;
    err_nxt   = 1'b0;

    case (state)
      S_RX: begin
        if (bus.RX_VALID) begin
          sreg_nxt = {sreg[DATA_W-BYTE_W-1:0], bus.RX_DATA};
          cnt_nxt  = cnt + CNT_W'(1);
          if (cnt == CNT_W'(BYTES - 1)) state_nxt = S_CALL;
        end
      end
      S_CALL: begin
        tcnt_nxt  = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.st == ALU_SEND) begin
          sreg_nxt  = bus.RES;
          tcnt_nxt  = '0;
          state_nxt = S_TX;
        end else if (tcnt == TW'(TIMEOUT - 2)) begin
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          tcnt_nxt  = '0;
          state_nxt = S_RX;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      S_TX: begin
        if (bus.TX_READY) begin
          sreg_nxt = {sreg[DATA_W-BYTE_W-1:0], BYTE_W'(0)};
          cnt_nxt  = cnt + CNT_W'(1);
          if (cnt == CNT_W'(BYTES - 1)) state_nxt = S_RX;
        end
      end
      default: state_nxt = S_RX;
    endcase

    rx_ready_nxt = (state_nxt == S_RX);
    busy_nxt     = (state_nxt != S_RX);
    call_nxt     = (state_nxt == S_CALL);
    tx_valid_nxt = (state_nxt == S_TX);
    tx_data_nxt  = tx_valid_nxt ? sreg_nxt[DATA_W-1 -: BYTE_W] : '0;
  end

  assign bus.RX_READY = rx_ready;
  assign bus.PD       = sreg;
  assign bus.call     = call_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.TX_VALID = tx_valid;
  assign bus.TX_DATA  = tx_data;

endmodule
